act_sparse_writer: RTL and testbench
====================================

Name: act_sparse_writer

Overview:
- Write-side producer for the sparse activation buffer.
- Accepts dense activation rows of IF_WIDTH values over a valid/ready handshake, optionally applies ReLU, and generates the per-row nonzero flag bitmap.
- Issues a flag-RAM write and a parallel column-data write per row, plus per-row nonzero count and per-tile totals.
- Sits between the feature-map load/DMA path and the activation buffer write ports.

Parameters:
- DATA_WIDTH, 8, bits per activation (signed two's complement).
- IF_WIDTH, 16, activations per row; also the flag bitmap width.
- ROW_CNT_WIDTH, 8, width of the row counter and cfg_rows.
- NNZ_WIDTH, 13, width of the per-tile nonzero total; must hold ROWS_MAX*IF_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches cfg_rows and begins a tile; ignored unless IDLE.
- cfg_rows  in  ROW_CNT_WIDTH  rows in the tile; 0 means immediate done.
- in_valid  in  1  dense row valid.
- in_ready  out  1  writer accepts a row this cycle.
- in_act  in  DATA_WIDTH*IF_WIDTH  dense row; column i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_req_act_flag  out  1  flag-RAM write strobe.
- wr_data_act_flag  out  IF_WIDTH  flag bitmap; bit i=1 iff column i is nonzero after optional ReLU.
- wr_req_act  out  1  column-data write strobe.
- wr_data_act  out  DATA_WIDTH*IF_WIDTH  column data, same packing as in_act.
- row_val_num  out  $clog2(IF_WIDTH)+1  popcount of the current flag; valid with the write strobes.
- nnz_total  out  NNZ_WIDTH  running nonzero count for the tile.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at tile end.

Behaviour:
- Reset, asynchronous and active-low, forces:
  - FSM to IDLE.
  - All outputs to 0: in_ready, wr_req_act_flag, wr_req_act, wr_data_act_flag, wr_data_act, row_val_num, nnz_total, busy, done.
  - Row counter to 0.
- FSM states:
  - IDLE -> RUN on start with cfg_rows!=0. start also clears nnz_total and the row counter.
  - IDLE -> DONE on start with cfg_rows==0; done pulses the next cycle.
  - RUN -> DRAIN when the accepted row is row cfg_rows-1.
  - DRAIN -> DONE after the last write strobe has issued (1 cycle).
  - DONE -> IDLE unconditionally; done=1 only in the DONE cycle.
- in_ready = (state==RUN) combinationally; it drops in the cycle after the last row is accepted.
- Handshake:
  - A row transfers when in_valid&&in_ready.
  - in_act must stay stable while in_valid=1 and in_ready=0.
  - The writer has no downstream backpressure; the buffer accepts every strobe.
- Pipeline, 1 cycle of latency:
  - Transfer at cycle T gives wr_req_act_flag=wr_req_act=1 at T+1.
  - At T+1, wr_data_act_flag, wr_data_act and row_val_num are registered from the row accepted at T.
  - Both strobes are always asserted together.
- Between rows, strobes are 0 and data/flag registers hold their last value.
- Flag rule: bit i = |col_i, using the post-ReLU value when ReLU is enabled.
- Zero columns are still written with value 0. The buffer relies on the flag, not on data gating.
- nnz_total:
  - Increments by row_val_num in the cycle the strobes are high.
  - Saturates at all-ones and does not wrap.
  - Holds after done until the next start.
- Row counter:
  - Increments per accepted row.
  - Compares against the cfg_rows value latched at start; later cfg_rows changes are ignored.
- start while busy or in DONE: ignored, no effect on counters.
- in_valid in IDLE/DRAIN/DONE: not accepted and no strobe; the row stays pending at the source.
- Reset mid-tile: everything is abandoned with no partial done. A strobe already registered is dropped (outputs forced 0).

Optional Feature:
- Macro ACT_SPARSE_WRITER_RELU_EN.
- Defined: each column is replaced by 0 when its sign bit is 1, before flag, data and popcount generation. Negative inputs yield flag=0 and data=0.
- Undefined: data passes unmodified; negative values count as nonzero.
- Latency is identical in both builds.

Decomposition:
- Shared package holds:
  - DATA_WIDTH/IF_WIDTH defaults.
  - FSM state enum {IDLE, RUN, DRAIN, DONE}.
  - Popcount width constant.
- One sub-module is natural: act_row_flag_gen. It is combinational: per-column optional ReLU, flag bitmap and popcount. It is reused later by the output-side compressor.

Test Plan:
- start, cfg_rows=1; row with columns 0,3,15 = 5,-2,1, rest 0 (ReLU off):
  - strobes high 1 cycle after accept;
  - wr_data_act_flag=16'h8009, row_val_num=3;
  - nnz_total=3, done pulses 2 cycles after accept.
- Same row with ACT_SPARSE_WRITER_RELU_EN defined: flag=16'h8001, column 3 data=0, row_val_num=2.
- cfg_rows=4, in_valid toggled 1,0,1,1,0,1:
  - exactly 4 strobe pulses;
  - in_ready=0 from the cycle after the 4th accept;
  - 5th offered row is not consumed.
- start with cfg_rows=0: done the next cycle, no strobes, busy stays 0.
- Reset asserted one cycle after a transfer in a 3-row tile:
  - all outputs 0 asynchronously, including the pending strobe;
  - after release the FSM is IDLE and a new start behaves normally.
- 2 rows of all-nonzero data followed by start pulses during RUN: starts are ignored, nnz_total=32, done pulses once.

Source files
------------

// File: rtl/act_sparse_writer_pkg.sv
// Shared types and default widths for the sparse activation writer and its
// row flag generator.
package act_sparse_writer_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned IF_WIDTH_DEF   = 16;
  localparam int unsigned CNT_WIDTH_DEF  = $clog2(IF_WIDTH_DEF) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/act_row_flag_gen.sv
// Combinational per-row optional ReLU, nonzero flag bitmap and popcount.
// Optional ReLU clamp enabled by ACT_SPARSE_WRITER_RELU_EN.
module act_row_flag_gen
  import act_sparse_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned IF_WIDTH   = IF_WIDTH_DEF
) (
  input  logic [DATA_WIDTH*IF_WIDTH-1:0] act_i,
  output logic [DATA_WIDTH*IF_WIDTH-1:0] act_o,
  output logic [IF_WIDTH-1:0]            flag_o,
  output logic [$clog2(IF_WIDTH):0]      cnt_o
);

  localparam int unsigned CW = $clog2(IF_WIDTH) + 1;

  logic [DATA_WIDTH-1:0] col;

  always_comb begin
    act_o  = '0;
    flag_o = '0;
    cnt_o  = '0;
    col    = '0;
    for (int unsigned i = 0; i < IF_WIDTH; i++) begin
      col = act_i[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef ACT_SPARSE_WRITER_RELU_EN
      if (col[DATA_WIDTH-1]) col = '0;
`endif
      act_o[i*DATA_WIDTH +: DATA_WIDTH] = col;
      flag_o[i] = |col;
      cnt_o     = cnt_o + CW'(flag_o[i]);
    end
  end

endmodule

// File: rtl/act_sparse_writer.sv
// Sparse activation buffer write-side producer: dense rows in, flag/data
// writes out with one cycle latency. ReLU via ACT_SPARSE_WRITER_RELU_EN.
module act_sparse_writer
  import act_sparse_writer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned IF_WIDTH      = IF_WIDTH_DEF,
  parameter int unsigned ROW_CNT_WIDTH = 8,
  parameter int unsigned NNZ_WIDTH     = 13
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ROW_CNT_WIDTH-1:0]       cfg_rows,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH*IF_WIDTH-1:0] in_act,
  output logic                           wr_req_act_flag,
  output logic [IF_WIDTH-1:0]            wr_data_act_flag,
  output logic                           wr_req_act,
  output logic [DATA_WIDTH*IF_WIDTH-1:0] wr_data_act,
  output logic [$clog2(IF_WIDTH):0]      row_val_num,
  output logic [NNZ_WIDTH-1:0]           nnz_total,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned CW = $clog2(IF_WIDTH) + 1;

  state_e                         state_q, state_d;
  logic [ROW_CNT_WIDTH-1:0]       cfg_q, cfg_d;
  logic [ROW_CNT_WIDTH-1:0]       row_q, row_d;
  logic [NNZ_WIDTH-1:0]           nnz_q, nnz_d;
  logic [NNZ_WIDTH:0]             nnz_sum;
  logic                           wr_q;
  logic [IF_WIDTH-1:0]            flag_q;
  logic [DATA_WIDTH*IF_WIDTH-1:0] data_q;
  logic [CW-1:0]                  cnt_q;

  logic                           fire;
  logic [DATA_WIDTH*IF_WIDTH-1:0] gen_act;
  logic [IF_WIDTH-1:0]            gen_flag;
  logic [CW-1:0]                  gen_cnt;

  act_row_flag_gen #(
    .DATA_WIDTH (DATA_WIDTH),
    .IF_WIDTH   (IF_WIDTH)
  ) u_flag_gen (
    .act_i  (in_act),
    .act_o  (gen_act),
    .flag_o (gen_flag),
    .cnt_o  (gen_cnt)
  );

  assign in_ready = (state_q == RUN);
  assign fire     = in_ready && in_valid;

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    row_d   = row_q;
    nnz_d   = nnz_q;
    nnz_sum = {1'b0, nnz_q} + (NNZ_WIDTH+1)'(cnt_q);
    // Saturating accumulate of the row just written.
    if (wr_q) nnz_d = nnz_sum[NNZ_WIDTH] ? '1 : nnz_sum[NNZ_WIDTH-1:0];
    case (state_q)
      IDLE: begin
        if (start) begin
          cfg_d   = cfg_rows;
          row_d   = '0;
          nnz_d   = '0;
          state_d = (cfg_rows == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (fire) begin
          row_d = row_q + ROW_CNT_WIDTH'(1);
          if (row_q == cfg_q - ROW_CNT_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      row_q   <= '0;
      nnz_q   <= '0;
      wr_q    <= 1'b0;
      flag_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      row_q   <= row_d;
      nnz_q   <= nnz_d;
      wr_q    <= fire;
      if (fire) begin
        flag_q <= gen_flag;
        data_q <= gen_act;
        cnt_q  <= gen_cnt;
      end
    end
  end

  assign wr_req_act_flag  = wr_q;
  assign wr_req_act       = wr_q;
  assign wr_data_act_flag = flag_q;
  assign wr_data_act      = data_q;
  assign row_val_num      = cnt_q;
  assign nnz_total        = nnz_q;
  assign busy             = (state_q == RUN) || (state_q == DRAIN);
  assign done             = (state_q == DONE);

endmodule

// File: tb/tb_act_sparse_writer.sv
// Scoreboard bench for act_sparse_writer: stimulus pushes expected writes,
// a negedge monitor pops and compares every strobe.
module tb_act_sparse_writer;

  localparam int DW = 8;
  localparam int IW = 16;
  localparam int W  = DW * IW;
  localparam int CW = 5;
  localparam int NNZ_MAX = 8191;

  logic          clk, reset, start, in_valid, in_ready;
  logic [7:0]    cfg_rows;
  logic [W-1:0]  in_act;
  logic          wr_req_act_flag, wr_req_act, busy, done;
  logic [IW-1:0] wr_data_act_flag;
  logic [W-1:0]  wr_data_act;
  logic [CW-1:0] row_val_num;
  logic [12:0]   nnz_total;

  act_sparse_writer #(
    .DATA_WIDTH    (DW),
    .IF_WIDTH      (IW),
    .ROW_CNT_WIDTH (8),
    .NNZ_WIDTH     (13)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .cfg_rows         (cfg_rows),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_act           (in_act),
    .wr_req_act_flag  (wr_req_act_flag),
    .wr_data_act_flag (wr_data_act_flag),
    .wr_req_act       (wr_req_act),
    .wr_data_act      (wr_data_act),
    .row_val_num      (row_val_num),
    .nnz_total        (nnz_total),
    .busy             (busy),
    .done             (done)
  );

  typedef struct packed {
    logic [IW-1:0] flag;
    logic [W-1:0]  data;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   model_nnz = 0;
  int   strobe_cnt = 0;
  int   done_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: per column, optional clamp of negatives, then flag = value!=0.
  function automatic exp_t model(input logic [W-1:0] row);
    exp_t e;
    int   v;
    e = '0;
    for (int i = 0; i < IW; i++) begin
      v = int'(signed'(row[i*DW +: DW]));
`ifdef ACT_SPARSE_WRITER_RELU_EN
      if (v < 0) v = 0;
`endif
      e.data[i*DW +: DW] = v[DW-1:0];
      if (v != 0) begin
        e.flag[i] = 1'b1;
        e.cnt     = e.cnt + 1'b1;
      end
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_row(input int zero_pct, input bit pos_only);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < IW; i++) begin
      if ($urandom_range(99) >= zero_pct)
        r[i*DW +: DW] = pos_only ? 8'($urandom_range(127, 1)) : 8'($urandom_range(255, 1));
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (wr_req_act_flag || wr_req_act)
        check("strobe_pair", W'(wr_req_act), W'(wr_req_act_flag));
      if (wr_req_act_flag) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_strobe: got strobe with flag %0h, required none", wr_data_act_flag);
        end else begin
          mon_e = exp_q.pop_front();
          check("flag", W'(wr_data_act_flag), W'(mon_e.flag));
          check("data", wr_data_act, mon_e.data);
          check("row_val_num", W'(row_val_num), W'(mon_e.cnt));
          check("nnz_before_row", W'(nnz_total), W'(model_nnz));
          model_nnz = model_nnz + int'(mon_e.cnt);
          if (model_nnz > NNZ_MAX) model_nnz = NNZ_MAX;
        end
      end
      if (done) begin
        done_cnt++;
        check("nnz_at_done", W'(nnz_total), W'(model_nnz));
      end
    end
  end

  task automatic do_start(input int rows, input bit accepted);
    cfg_rows = 8'(rows);
    start    = 1'b1;
    if (accepted) model_nnz = 0;
    @(posedge clk); #1;
    start    = 1'b0;
    cfg_rows = 8'($urandom);
  endtask

  // Offer a row after gap idle cycles; returns 1ns after the accepting edge.
  task automatic send_row(input logic [W-1:0] row, input int gap);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_act   = row;
    in_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(row));
        ok = 1'b1;
      end
      @(posedge clk); #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    check("row_accepted", W'(ok), W'(1));
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1;
    check(name, W'(seen), W'(1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [W-1:0] row;
    int s0, d0, rows;
    reset = 1'b0; start = 1'b0; cfg_rows = '0; in_valid = 1'b0; in_act = '0;
    #23;
    check("rst_ctrl", W'({in_ready, wr_req_act_flag, wr_req_act, busy, done}), '0);
    check("rst_flag", W'(wr_data_act_flag), '0);
    check("rst_data", wr_data_act, '0);
    check("rst_cnt_nnz", W'({row_val_num, nnz_total}), '0);
    @(posedge clk); #3 reset = 1'b1;
    idle(2);

    // Single row: columns 0,3,15 = 5,-2,1.
    row = '0;
    row[0*DW +: DW]  = 8'd5;
    row[3*DW +: DW]  = 8'hFE;
    row[15*DW +: DW] = 8'd1;
    do_start(1, 1'b1);
    send_row(row, 0);
    @(negedge clk);
    check("t1_strobe", W'(wr_req_act_flag), W'(1));
`ifdef ACT_SPARSE_WRITER_RELU_EN
    check("t1_flag", W'(wr_data_act_flag), W'(16'h8001));
    check("t1_cnt", W'(row_val_num), W'(2));
    check("t1_col3", W'(wr_data_act[3*DW +: DW]), W'(0));
`else
    check("t1_flag", W'(wr_data_act_flag), W'(16'h8009));
    check("t1_cnt", W'(row_val_num), W'(3));
    check("t1_col3", W'(wr_data_act[3*DW +: DW]), W'(8'hFE));
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_done", W'(done), W'(1));
`ifdef ACT_SPARSE_WRITER_RELU_EN
    check("t1_nnz", W'(nnz_total), W'(2));
`else
    check("t1_nnz", W'(nnz_total), W'(3));
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check("t1_done_once", W'({done, busy}), '0);
    idle(2);

    // Four rows with valid pattern 1,0,1,1,0,1, then a fifth offer.
    s0 = strobe_cnt;
    do_start(4, 1'b1);
    send_row(rand_row(40, 1'b0), 0);
    send_row(rand_row(40, 1'b0), 1);
    send_row(rand_row(40, 1'b0), 0);
    send_row(rand_row(40, 1'b0), 1);
    @(negedge clk);
    check("t3_ready_drop", W'(in_ready), W'(0));
    in_act   = rand_row(0, 1'b0);
    in_valid = 1'b1;
    wait_done("t3_done");
    idle(3);
    check("t3_ready_idle", W'(in_ready), W'(0));
    in_valid = 1'b0;
    check("t3_strobes", W'(strobe_cnt - s0), W'(4));
    check("t3_queue_empty", W'(exp_q.size()), '0);

    // Zero-row tile.
    s0 = strobe_cnt;
    do_start(0, 1'b1);
    @(negedge clk);
    check("t4_done_next", W'(done), W'(1));
    check("t4_busy", W'(busy), W'(0));
    idle(3);
    check("t4_no_strobe", W'(strobe_cnt - s0), '0);

    // Reset one cycle after a transfer in a 3-row tile.
    do_start(3, 1'b1);
    send_row(rand_row(0, 1'b1), 0);
    #1 reset = 1'b0;
    #1;
    check("t5_ctrl", W'({in_ready, wr_req_act_flag, wr_req_act, busy, done}), '0);
    check("t5_flag", W'(wr_data_act_flag), '0);
    check("t5_data", wr_data_act, '0);
    check("t5_cnt_nnz", W'({row_val_num, nnz_total}), '0);
    exp_q.delete();
    model_nnz = 0;
    idle(2);
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    in_act   = rand_row(0, 1'b1);
    in_valid = 1'b1;
    idle(3);
    @(negedge clk);
    check("t5_idle", W'({in_ready, busy}), '0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    d0 = done_cnt;
    do_start(2, 1'b1);
    send_row(rand_row(30, 1'b0), 0);
    send_row(rand_row(30, 1'b0), 0);
    wait_done("t5_done");
    check("t5_done_once", W'(done_cnt - d0), W'(1));

    // All-nonzero rows with start pulses while busy.
    d0 = done_cnt;
    do_start(2, 1'b1);
    send_row(rand_row(0, 1'b1), 0);
    do_start(5, 1'b0);
    do_start(0, 1'b0);
    send_row(rand_row(0, 1'b1), 1);
    do_start(7, 1'b0);
    wait_done("t6_done");
    idle(3);
    check("t6_nnz", W'(nnz_total), W'(32));
    check("t6_done_once", W'(done_cnt - d0), W'(1));

    // Randomized tiles.
    for (int t = 0; t < 8; t++) begin
      d0   = done_cnt;
      rows = $urandom_range(6, 1);
      do_start(rows, 1'b1);
      for (int r = 0; r < rows; r++)
        send_row(rand_row(50, 1'b0), $urandom_range(2));
      wait_done("rand_done");
      idle(2);
      check("rand_done_once", W'(done_cnt - d0), W'(1));
      check("rand_queue_empty", W'(exp_q.size()), '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
